// File: rtl/conv_output_collector_pkg.sv
// Shared definitions for the convolution output collector and its control path.
package conv_output_collector_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_IMAGE_SIZE  = 28;
  localparam int unsigned DEF_KERNEL_SIZE = 5;

  // Collector state encoding
  localparam logic [1:0] ST_COLLECT    = 2'b00;
  localparam logic [1:0] ST_DRAIN_FILL = 2'b01;
  localparam logic [1:0] ST_DRAIN      = 2'b10;

  // Side length of a 'valid' convolution output map
  function automatic int unsigned out_size(input int unsigned img, input int unsigned k);
    return img - 2 * (k / 2);
  endfunction

endpackage

// File: rtl/conv_output_collector_fmap_buffer_sdp.sv
// Simple dual-port feature-map buffer: one write port, one registered read port (1-cycle latency).
module fmap_buffer_sdp
  import conv_output_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 576,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; holds its value while i_rd_en is low
  always_ff @(posedge clk) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv_output_collector.sv
// Collects one OUT_SIZE x OUT_SIZE convolution result map, then drains it as a tagged valid/ready stream.
module conv_output_collector
  import conv_output_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned IMAGE_SIZE  = DEF_IMAGE_SIZE,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_row,
  output logic [4:0]            out_col,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned OUT_SIZE = out_size(IMAGE_SIZE, KERNEL_SIZE);
  localparam int unsigned DEPTH    = OUT_SIZE * OUT_SIZE;
  localparam int unsigned ADDR_W   = $clog2(DEPTH);
  localparam int unsigned RC_W     = 5;
  localparam logic [RC_W-1:0] LAST_RC = RC_W'(OUT_SIZE - 1);
  localparam logic [RC_W-1:0] PENU_RC = RC_W'(OUT_SIZE - 2);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [RC_W-1:0]   r_wr_row;
  logic [RC_W-1:0]   r_wr_col;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [RC_W-1:0]   r_rd_row;
  logic [RC_W-1:0]   r_rd_col;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_frame_done;
  logic              r_overrun;
  logic              r_busy;

  logic              w_wr_en;
  logic              w_wr_final;
  logic              w_hs;
  logic              w_hs_last;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr_en    = (r_state == ST_COLLECT) && in_valid;
  assign w_wr_final = w_wr_en && (r_wr_row == LAST_RC) && (r_wr_col == LAST_RC);
  assign w_hs       = r_out_valid && out_ready;
  assign w_hs_last  = w_hs && r_out_last;
  // Read ahead: fetch the next beat on every non-final handshake so out_valid never bubbles
  assign w_rd_en    = (r_state == ST_DRAIN_FILL) || (w_hs && !r_out_last);
  assign w_rd_addr  = (r_state == ST_DRAIN_FILL) ? '0 : r_rd_addr + ADDR_W'(1);

  fmap_buffer_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (out_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_COLLECT;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COLLECT:    if (w_wr_final) w_next_state = ST_DRAIN_FILL;
      ST_DRAIN_FILL: w_next_state = ST_DRAIN;
      ST_DRAIN:      if (w_hs_last) w_next_state = ST_COLLECT;
      default:       w_next_state = ST_COLLECT;
    endcase
  end

  // Raster-order write counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_addr <= '0;
    end else if (w_wr_en) begin
      r_wr_addr <= w_wr_final ? '0 : r_wr_addr + ADDR_W'(1);
      if (r_wr_col == LAST_RC) begin
        r_wr_col <= '0;
        r_wr_row <= (r_wr_row == LAST_RC) ? '0 : r_wr_row + RC_W'(1);
      end else begin
        r_wr_col <= r_wr_col + RC_W'(1);
      end
    end
  end

  // Drain side: beat tags track the address whose data sits on the read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_rd_addr   <= '0;
    end else if (r_state == ST_DRAIN_FILL) begin
      r_out_valid <= 1'b1;
      r_out_last  <= (OUT_SIZE == 1);
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_rd_addr   <= '0;
    end else if (w_hs_last) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_rd_addr   <= '0;
    end else if (w_hs) begin
      r_rd_addr  <= w_rd_addr;
      r_out_last <= (r_rd_row == LAST_RC) && (r_rd_col == PENU_RC);
      if (r_rd_col == LAST_RC) begin
        r_rd_col <= '0;
        r_rd_row <= r_rd_row + RC_W'(1);
      end else begin
        r_rd_col <= r_rd_col + RC_W'(1);
      end
    end
  end

  // Status flags: end-of-frame pulse, sticky overrun, busy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_hs_last;
      r_overrun    <= r_overrun || (in_valid && (r_state != ST_COLLECT));
      r_busy       <= (w_next_state != ST_COLLECT);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_row    = r_rd_row;
  assign out_col    = r_rd_col;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: doc/conv_output_collector.md
Name: conv_output_collector

Overview:
- Receives the convolver's result stream, gated by the control path's `enable`, and assembles one full output feature map in an internal buffer.
- OUT_SIZE x OUT_SIZE results are written in raster order. The map is then drained to the next layer over a valid/ready stream carrying row/col tags and an end-of-frame marker.
- Sits between the convolver datapath and the downstream layer/pool stage; it is the consuming end of the `enable` qualifier.

Parameters:
- DATA_WIDTH, 16: width of one convolution result.
- IMAGE_SIZE, 28: input image side length.
- KERNEL_SIZE, 5: kernel side length.
- OUT_SIZE, IMAGE_SIZE-2*(KERNEL_SIZE/2) = 24: localparam, derived, never overridden; output map side length.
- ADDR_W, $clog2(OUT_SIZE*OUT_SIZE) = 10: localparam; buffer address width.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  convolver `enable`; result present this cycle.
- in_data  in  DATA_WIDTH  convolver result, sampled when in_valid=1.
- out_valid  out  1  out_data/out_row/out_col/out_last valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  buffered result.
- out_row  out  5  row index of out_data, 0..OUT_SIZE-1.
- out_col  out  5  column index of out_data, 0..OUT_SIZE-1.
- out_last  out  1  high with the final beat of the frame (row=col=OUT_SIZE-1).
- frame_done  out  1  one-cycle pulse after the final beat handshakes.
- overrun  out  1  sticky; set when in_valid=1 arrives while not in COLLECT.
- busy  out  1  high in DRAIN_FILL or DRAIN.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - state=COLLECT; write row/col counters=0; read counters=0.
  - out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, frame_done=0, overrun=0, busy=0.
  - Buffer contents are not cleared.
  - Reset asserted mid-frame or mid-drain discards the partial frame; the next in_valid after reset is written to (0,0).
- States:
  - COLLECT: every cycle with in_valid=1 writes in_data to address wr_row*OUT_SIZE+wr_col, then advances col. At col=OUT_SIZE-1 the block wraps col to 0 and increments row. in_valid gaps of any length (the row-shift bubbles) are allowed and change nothing.
  - COLLECT -> DRAIN_FILL: on the write of (OUT_SIZE-1, OUT_SIZE-1). Write counters reset to 0.
  - DRAIN_FILL: exactly one cycle. Issues the buffer read of address 0 (1-cycle synchronous read). Goes to DRAIN.
  - DRAIN:
    - out_valid=1. out_data/out_row/out_col/out_last hold stable while out_valid=1 and out_ready=0.
    - On handshake (out_valid & out_ready), the next address's read data is presented the following cycle, so out_valid stays continuously 1 with out_ready tied high: one beat per cycle, no bubbles.
    - Requires a read-ahead or a one-entry skid register.
    - The final beat carries out_last=1.
  - DRAIN -> COLLECT: on handshake of the final beat. Next cycle: out_valid=0 and frame_done=1 for exactly one cycle.
- Latency: last input write to first out_valid = 2 cycles. Full drain with out_ready=1 = OUT_SIZE^2 cycles.
- in_valid outside COLLECT: data dropped, no write, overrun<=1. overrun clears only on reset.
- Same-cycle events: the final-input write and the transition to DRAIN_FILL happen together. in_valid during DRAIN_FILL or DRAIN is an overrun.
- Counters are unsigned and wrap only via explicit compare to OUT_SIZE-1; no arithmetic overflow paths.
- busy = (state != COLLECT).

Decomposition:
- Shared package holds:
  - OUT_SIZE derivation function: out_size(img, k) = img - 2*(k/2).
  - State encoding: COLLECT=2'b00, DRAIN_FILL=2'b01, DRAIN=2'b10.
  - Default DATA_WIDTH/IMAGE_SIZE/KERNEL_SIZE, reused by the control path and this block.
- One sub-module: fmap_buffer_sdp. Simple dual-port RAM, depth OUT_SIZE^2, width DATA_WIDTH, one write port, one registered read port with 1-cycle latency. Inferable as block RAM.

Test Plan:
- Reset, then 576 in_valid beats with in_data=index (0..575) and out_ready=1 -> out_valid rises 2 cycles after beat 575; beats come out as 0..575 with row/col = (i/24, i%24); out_last only on beat 575; frame_done pulses one cycle after it.
- Same 576 beats inserted as rows of 24 (or 25-cycle bursts) separated by 5-cycle in_valid=0 gaps -> output identical to the previous scenario; gaps cause no writes.
- Drain with out_ready toggling 1,0,0,1 repeating -> no beat lost or duplicated; data stable while out_ready=0; all 576 values in order.
- in_valid=1 with in_data=16'hDEAD during DRAIN -> overrun=1 and stays 1; drained data unaffected; the next frame still collects correctly.
- Reset asserted after 300 input beats, then a fresh 576-beat frame with in_data=1000+i -> output is exactly 1000..1575; no stale entries.
- Two back-to-back frames, the second starting the cycle after frame_done -> both drain correctly; busy=0 between drain end and next DRAIN_FILL.
